// File: rtl/elmo_bram_pkg.sv
// Shared definitions for the BRAM access initiators: FSM encoding and RAM timing.
package elmo_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  localparam int unsigned RAM_RD_LATENCY = 1;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with simultaneous push/pop at any occupancy.
// Head word is presented combinationally on rdata; depth need not be a power of 2.
module stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read initiator for a single-port BRAM with 1-cycle registered read.
// Issues sequential reads under a FIFO credit check and streams words over valid/ready.
module bram_burst_reader
  import elmo_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADD_WIDTH-1:0]  base_addr,
  input  logic [ADD_WIDTH:0]    len,
  output logic                  busy,
  output logic                  done,
  output logic [ADD_WIDTH-1:0]  ram_add,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int CNT_W  = ADD_WIDTH + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = FCNT_W + 1;

  rd_state_e            state_q, state_d;
  logic [ADD_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     accepted_q, accepted_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;

  logic                  fifo_full, fifo_empty;
  logic [FCNT_W-1:0]     fifo_count;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  pop, issue_ok, last_issue, last_accept;
  logic [OCC_W-1:0]      occ;

  stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata ({inflight_last_q, ram_rdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid = ~fifo_empty;
  assign m_last  = fifo_rdata[DATA_WIDTH] & m_valid;
  assign m_data  = m_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
  assign ram_add = addr_q;
  assign ram_we  = 1'b0;
  assign ram_oe  = ram_cs;

  // Credit: the word being issued needs a FIFO slot once the in-flight word lands,
  // counting the slot freed by a pop this cycle.
  always_comb begin
    pop         = m_valid & m_ready;
    occ         = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    issue_ok    = !(fifo_full && !pop) && (occ < OCC_W'(FIFO_DEPTH) + OCC_W'(pop));
    last_issue  = ((issued_q + CNT_W'(1)) == len_q);
    last_accept = pop && !inflight_q && ((accepted_q + CNT_W'(1)) == len_q);
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    accepted_d      = accepted_q;
    ram_cs          = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    inflight_last_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start) begin
          addr_d     = base_addr;
          len_d      = len;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy   = 1'b1;
        ram_cs = issue_ok;
        if (pop) accepted_d = accepted_q + CNT_W'(1);
        if (issue_ok) begin
          addr_d          = addr_q + ADD_WIDTH'(1);
          issued_d        = issued_q + CNT_W'(1);
          inflight_last_d = last_issue;
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop) accepted_d = accepted_q + CNT_W'(1);
        if (last_accept) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d = ram_cs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      accepted_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      accepted_q      <= accepted_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader paired with a behavioural 1-cycle-latency RAM.
module tb_bram_burst_reader;

  localparam int DW       = 32;
  localparam int AW       = 10;
  localparam int DEPTH    = 2;
  localparam int RAM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] ram_add;
  logic          ram_cs, ram_we, ram_oe;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, m_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bram_burst_reader #(
    .DATA_WIDTH (DW),
    .ADD_WIDTH  (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_add   (ram_add),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_rdata (ram_rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  logic [DW-1:0] mem [RAM_SIZE];
  always @(posedge clk) begin
    if (ram_cs && !ram_we) ram_rdata <= mem[ram_add];
  end

  // Monitor: records transfers/issues and tracks occupancy independently of the DUT.
  int            cyc = 0;
  int            done_cnt = 0, done_cyc = -1;
  int            credit_viol = 0, stable_viol = 0, oe_viol = 0;
  int            cs_tot = 0, pop_tot = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW-1:0] rx_data[$];
  logic          rx_last[$];
  int            rx_cyc[$];
  logic [AW-1:0] cs_add[$];
  int            cs_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ram_oe !== ram_cs) oe_viol <= oe_viol + 1;
    if (ram_cs === 1'b1) begin
      cs_add.push_back(ram_add);
      cs_cyc.push_back(cyc);
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      rx_data.push_back(m_data);
      rx_last.push_back(m_last);
      rx_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rst) begin
      cs_tot     <= 0;
      pop_tot    <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (ram_cs === 1'b1 && (cs_tot - pop_tot - int'(m_valid && m_ready) + 1 > DEPTH))
        credit_viol <= credit_viol + 1;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        stable_viol <= stable_viol + 1;
      cs_tot     <= cs_tot + int'(ram_cs === 1'b1);
      pop_tot    <= pop_tot + int'(m_valid === 1'b1 && m_ready === 1'b1);
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l, output int t0);
    step();
    base_addr = b;
    len       = l;
    start     = 1'b1;
    t0        = cyc;
    step();
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int mode, input int budget, input int d0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (mode == 1) m_ready = (k >= 4 && k <= 8) ? 1'b0 : ((k % 2) == 0);
      else           m_ready = 1'b1;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    settle();
    vectors++;
    if ({busy, done, ram_cs, ram_oe, ram_we, m_valid, m_last} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {busy, done, ram_cs, ram_oe, ram_we, m_valid, m_last});
    end
    vectors++;
    if (ram_add !== '0) begin
      miscompares++;
      $display("FAIL reset_add: got %h expected 000", ram_add);
    end
    rst = 1'b0;
    step();
    step();
    settle();
    vectors++;
    if ({busy, done, ram_cs, m_valid} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b expected 0000", {busy, done, ram_cs, m_valid});
    end
  endtask

  task automatic test_basic();
    int t0, d0, r0, c0;
    bit ok;
    logic [7:0] lm;
    m_ready = 1'b1;
    d0 = done_cnt; r0 = rx_data.size(); c0 = cs_add.size();
    start_burst(10'h010, 11'd8, t0);
    settle();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    run_until_done(0, 40, d0, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_timeout: got no done expected done");
    end
    vectors++;
    if (rx_data.size() - r0 !== 8) begin
      miscompares++;
      $display("FAIL basic_count: got %0d expected 8", rx_data.size() - r0);
    end
    lm = '0;
    for (int i = 0; i < 8 && r0 + i < rx_data.size(); i++) begin
      lm[i] = rx_last[r0+i];
      vectors++;
      if (rx_data[r0+i] !== DW'(32'h10 + i)) begin
        miscompares++;
        $display("FAIL basic_data[%0d]: got %h expected %h", i, rx_data[r0+i], 32'h10 + i);
      end
    end
    vectors++;
    if (lm !== 8'h80) begin
      miscompares++;
      $display("FAIL basic_last: got %b expected 10000000", lm);
    end
    vectors++;
    if (cs_cyc[c0] !== t0 + 1) begin
      miscompares++;
      $display("FAIL basic_cs_latency: got %0d expected %0d", cs_cyc[c0] - t0, 1);
    end
    vectors++;
    if (rx_cyc[r0] !== t0 + 3 || rx_cyc[r0+7] !== t0 + 10) begin
      miscompares++;
      $display("FAIL basic_stream_timing: got first %0d last %0d expected 3 10", rx_cyc[r0] - t0, rx_cyc[r0+7] - t0);
    end
    vectors++;
    if (done_cyc !== rx_cyc[r0+7] + 1 || done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL basic_done: got at +%0d count %0d expected +11 count 1", done_cyc - t0, done_cnt - d0);
    end
    settle();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_wrap();
    int t0, d0, r0, c0;
    bit ok;
    logic [AW-1:0] e;
    m_ready = 1'b1;
    d0 = done_cnt; r0 = rx_data.size(); c0 = cs_add.size();
    start_burst(10'h3FE, 11'd4, t0);
    run_until_done(0, 40, d0, ok);
    vectors++;
    if (!ok || cs_add.size() - c0 !== 4 || rx_data.size() - r0 !== 4) begin
      miscompares++;
      $display("FAIL wrap_counts: got done %0d cs %0d rx %0d expected 1 4 4", ok, cs_add.size() - c0, rx_data.size() - r0);
    end
    for (int i = 0; i < 4 && c0 + i < cs_add.size() && r0 + i < rx_data.size(); i++) begin
      e = 10'h3FE + AW'(i);
      vectors++;
      if (cs_add[c0+i] !== e || rx_data[r0+i] !== DW'(e)) begin
        miscompares++;
        $display("FAIL wrap_word[%0d]: got add %h data %h expected %h", i, cs_add[c0+i], rx_data[r0+i], e);
      end
    end
  endtask

  task automatic test_backpressure();
    int t0, d0, r0, cv0, sv0;
    bit ok;
    logic [7:0] lm;
    m_ready = 1'b0;
    d0 = done_cnt; r0 = rx_data.size(); cv0 = credit_viol; sv0 = stable_viol;
    start_burst(10'h040, 11'd8, t0);
    run_until_done(1, 80, d0, ok);
    m_ready = 1'b1;
    vectors++;
    if (!ok || rx_data.size() - r0 !== 8 || done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL bp_counts: got done %0d rx %0d pulses %0d expected 1 8 1", ok, rx_data.size() - r0, done_cnt - d0);
    end
    lm = '0;
    for (int i = 0; i < 8 && r0 + i < rx_data.size(); i++) begin
      lm[i] = rx_last[r0+i];
      vectors++;
      if (rx_data[r0+i] !== DW'(32'h40 + i)) begin
        miscompares++;
        $display("FAIL bp_data[%0d]: got %h expected %h", i, rx_data[r0+i], 32'h40 + i);
      end
    end
    vectors++;
    if (lm !== 8'h80) begin
      miscompares++;
      $display("FAIL bp_last: got %b expected 10000000", lm);
    end
    vectors++;
    if (credit_viol - cv0 !== 0) begin
      miscompares++;
      $display("FAIL bp_credit: got %0d over-issues expected 0", credit_viol - cv0);
    end
    vectors++;
    if (stable_viol - sv0 !== 0) begin
      miscompares++;
      $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stable_viol - sv0);
    end
  endtask

  task automatic test_len0();
    int t0, d0, r0, c0;
    m_ready = 1'b1;
    d0 = done_cnt; r0 = rx_data.size(); c0 = cs_add.size();
    start_burst(10'h055, 11'd0, t0);
    settle();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_done: got done %b busy %b expected 1 0", done, busy);
    end
    step();
    settle();
    vectors++;
    if (done !== 1'b0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_after: got done %b valid %b expected 0 0", done, m_valid);
    end
    step();
    vectors++;
    if (cs_add.size() - c0 !== 0 || rx_data.size() - r0 !== 0 || done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL len0_activity: got cs %0d rx %0d pulses %0d expected 0 0 1", cs_add.size() - c0, rx_data.size() - r0, done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int t0, t1, d0, r0, c0;
    bit ok;
    m_ready = 1'b1;
    d0 = done_cnt; r0 = rx_data.size();
    start_burst(10'h080, 11'd8, t0);
    step();
    base_addr = 10'h300;
    len       = 11'd3;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    settle();
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 32'h82) begin
      miscompares++;
      $display("FAIL abort_third_word: got valid %b data %h expected 1 00000082", m_valid, m_data);
    end
    step();
    rst = 1'b0;
    settle();
    vectors++;
    if ({busy, done, ram_cs, ram_oe, m_valid, m_last} !== 6'b0 || ram_add !== '0 || m_data !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: got %b add %h data %h expected 000000 000 00000000", {busy, done, ram_cs, ram_oe, m_valid, m_last}, ram_add, m_data);
    end
    c0 = cs_add.size();
    repeat (10) step();
    vectors++;
    if (done_cnt - d0 !== 0 || cs_add.size() - c0 !== 0 || rx_data.size() - r0 !== 3) begin
      miscompares++;
      $display("FAIL abort_quiet: got pulses %0d cs %0d rx %0d expected 0 0 3", done_cnt - d0, cs_add.size() - c0, rx_data.size() - r0);
    end
    for (int i = 0; i < 3 && r0 + i < rx_data.size(); i++) begin
      vectors++;
      if (rx_data[r0+i] !== DW'(32'h80 + i)) begin
        miscompares++;
        $display("FAIL abort_data[%0d]: got %h expected %h", i, rx_data[r0+i], 32'h80 + i);
      end
    end
    d0 = done_cnt; r0 = rx_data.size();
    start_burst(10'h123, 11'd3, t1);
    run_until_done(0, 40, d0, ok);
    vectors++;
    if (!ok || rx_data.size() - r0 !== 3 || done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL fresh_counts: got done %0d rx %0d pulses %0d expected 1 3 1", ok, rx_data.size() - r0, done_cnt - d0);
    end
    for (int i = 0; i < 3 && r0 + i < rx_data.size(); i++) begin
      vectors++;
      if (rx_data[r0+i] !== DW'(32'h123 + i) || rx_last[r0+i] !== (i == 2)) begin
        miscompares++;
        $display("FAIL fresh_word[%0d]: got %h last %b expected %h last %b", i, rx_data[r0+i], rx_last[r0+i], 32'h123 + i, i == 2);
      end
    end
  endtask

  task automatic test_full();
    int t0, d0, r0, c0, errs, lasts;
    bit ok;
    m_ready = 1'b1;
    d0 = done_cnt; r0 = rx_data.size(); c0 = cs_add.size();
    start_burst(10'h200, 11'd1024, t0);
    run_until_done(0, 1100, d0, ok);
    vectors++;
    if (!ok || rx_data.size() - r0 !== 1024 || cs_add.size() - c0 !== 1024 || done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL full_counts: got done %0d rx %0d cs %0d pulses %0d expected 1 1024 1024 1", ok, rx_data.size() - r0, cs_add.size() - c0, done_cnt - d0);
    end
    errs = 0;
    lasts = 0;
    for (int i = 0; i < 1024 && r0 + i < rx_data.size(); i++) begin
      if (rx_data[r0+i] !== DW'((32'h200 + i) % RAM_SIZE)) errs++;
      if (rx_last[r0+i] === 1'b1) lasts++;
    end
    vectors++;
    if (errs !== 0) begin
      miscompares++;
      $display("FAIL full_data: got %0d bad words expected 0", errs);
    end
    vectors++;
    if (lasts !== 1 || rx_last[rx_data.size()-1] !== 1'b1) begin
      miscompares++;
      $display("FAIL full_last: got %0d last flags expected 1 on final word", lasts);
    end
    vectors++;
    if (oe_viol !== 0) begin
      miscompares++;
      $display("FAIL oe_tracks_cs: got %0d differing cycles expected 0", oe_viol);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
    for (int i = 0; i < RAM_SIZE; i++) mem[i] = DW'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_abort();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
